// File: rtl/uart_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single UART memory controller.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed dm-over-if priority for round robin on ties.
module uart_mem_arbiter (
  input  logic         CLK,
  input  logic         RST,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic [255:0] if_rdata,
  output logic         if_ack,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [31:0]  dm_addr,
  input  logic [255:0] dm_wdata,
  output logic [255:0] dm_rdata,
  output logic         dm_ack,
  output logic         mem_read_op,
  output logic         mem_write_op,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_busy,
  input  logic         mem_done,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_DM   = 2'b10;

  state_t         state, state_n;
  logic [1:0]     grant_q, grant_n;
  logic [31:0]    addr_l;
  logic           we_l;
  logic [255:0]   wdata_l;
  logic           latch_en;
  logic           sel_dm;
  logic           capture;

  // mem_busy is status only; the FSM is paced purely by mem_done.
  logic unused_busy;
  assign unused_busy = mem_busy;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port was granted last; reset to fetch so dm wins the first tie.
  logic last_dm;
  assign sel_dm = dm_req & (~if_req | ~last_dm);

  always_ff @(posedge CLK) begin
    if (RST)           last_dm <= 1'b0;
    else if (latch_en) last_dm <= sel_dm;
  end
`else
  assign sel_dm = dm_req;
`endif

  always_comb begin
    state_n  = state;
    grant_n  = grant_q;
    latch_en = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (if_req | dm_req) begin
          latch_en = 1'b1;
          grant_n  = sel_dm ? GNT_DM : GNT_IF;
          state_n  = SERVE;
        end
      end
      SERVE: begin
        if (mem_done) begin
          capture = ~we_l;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        grant_n = GNT_NONE;
        state_n = IDLE;
      end
      default: begin
        grant_n = GNT_NONE;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant_q  <= GNT_NONE;
      addr_l   <= '0;
      we_l     <= 1'b0;
      wdata_l  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      if (latch_en) begin
        addr_l  <= sel_dm ? dm_addr : if_addr;
        we_l    <= sel_dm & dm_we;
        wdata_l <= sel_dm ? dm_wdata : '0;
      end
      // grant_q still names the winner on the mem_done edge.
      if (capture) begin
        if (grant_q == GNT_DM) dm_rdata <= mem_rdata;
        else                   if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_read_op  = (state == SERVE) & ~we_l;
  assign mem_write_op = (state == SERVE) &  we_l;
  assign mem_addr     = addr_l;
  assign mem_wdata    = wdata_l;
  assign if_ack       = (state == RELEASE) & (grant_q == GNT_IF);
  assign dm_ack       = (state == RELEASE) & (grant_q == GNT_DM);
  assign grant        = grant_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter: per-cycle vector table for a fetch read,
// then hand sequences for write, tie arbitration, stray mem_done and reset-abort.
module tb_uart_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic         if_req;
  logic [31:0]  if_addr;
  logic [255:0] if_rdata;
  logic         if_ack;
  logic         dm_req;
  logic         dm_we;
  logic [31:0]  dm_addr;
  logic [255:0] dm_wdata;
  logic [255:0] dm_rdata;
  logic         dm_ack;
  logic         mem_read_op;
  logic         mem_write_op;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_busy;
  logic         mem_done;
  logic [1:0]   grant;

  int n_checks = 0;
  int n_fail   = 0;

  uart_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done),
    .grant(grant)
  );

  always #5 CLK = ~CLK;

  // Inputs change at the falling edge; outputs are compared 1 time unit later.
  task automatic step();
    @(negedge CLK);
    mem_busy = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rop, input logic wop,
                         input logic [1:0] gnt, input logic ia, input logic da);
    #1;
    chk({tag, "_rop"},   256'(mem_read_op),  256'(rop));
    chk({tag, "_wop"},   256'(mem_write_op), 256'(wop));
    chk({tag, "_grant"}, 256'(grant),        256'(gnt));
    chk({tag, "_ifack"}, 256'(if_ack),       256'(ia));
    chk({tag, "_dmack"}, 256'(dm_ack),       256'(da));
  endtask

  typedef struct {
    logic         if_req;
    logic         dm_req;
    logic         done;
    logic [255:0] rdata;
    logic         rop;
    logic         wop;
    logic [1:0]   gnt;
    logic         if_ack;
    logic         dm_ack;
  } vec_t;

  vec_t tbl[8];

  localparam logic [255:0] PAT_A5   = {32{8'hA5}};
  localparam logic [255:0] PAT_JUNK = {32{8'h3C}};
  localparam logic [255:0] PAT_77   = {32{8'h77}};
  localparam logic [255:0] PAT_66   = {32{8'h66}};

  initial begin
    RST = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_busy = 0; mem_done = 0;

    // Fetch read with mem_done in the 5th SERVE cycle.
    tbl[0] = '{1'b1, 1'b0, 1'b0, PAT_JUNK, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    for (int i = 1; i <= 4; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, PAT_JUNK, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, PAT_A5,   1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, PAT_JUNK, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, PAT_JUNK, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

    // Reset state, sampled while RST is still high.
    step(); step();
    chk_ctl("rst", 0, 0, 2'b00, 0, 0);
    chk("rst_maddr", 256'(mem_addr), 256'd0);
    chk("rst_mwdata", mem_wdata, '0);
    chk("rst_ifrdata", if_rdata, '0);
    chk("rst_dmrdata", dm_rdata, '0);
    RST = 1'b0;
    step();

    if_addr = 32'h100;
    for (int i = 0; i < 8; i++) begin
      if_req    = tbl[i].if_req;
      dm_req    = tbl[i].dm_req;
      mem_done  = tbl[i].done;
      mem_rdata = tbl[i].rdata;
      chk_ctl($sformatf("fetch_v%0d", i), tbl[i].rop, tbl[i].wop, tbl[i].gnt,
              tbl[i].if_ack, tbl[i].dm_ack);
      if (i >= 1 && i <= 5) chk($sformatf("fetch_v%0d_maddr", i), 256'(mem_addr), 256'h100);
      step();
    end
    mem_done = 0;
    chk("fetch_ifrdata", if_rdata, PAT_A5);

    // Data write; address change mid-SERVE must not leak through.
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 256'h1234;
    step();
    chk_ctl("wr_s1", 0, 1, 2'b10, 0, 0);
    chk("wr_s1_maddr", 256'(mem_addr), 256'h200);
    chk("wr_s1_mwdata", mem_wdata, 256'h1234);
    dm_addr = 32'h999; dm_wdata = '1;
    step();
    chk("wr_s2_maddr", 256'(mem_addr), 256'h200);
    chk("wr_s2_mwdata", mem_wdata, 256'h1234);
    mem_done = 1; mem_rdata = PAT_JUNK;
    step();
    mem_done = 0;
    chk_ctl("wr_rel", 0, 0, 2'b10, 0, 1);
    chk("wr_dmrdata", dm_rdata, '0);
    step();
    dm_req = 0; dm_we = 0;
    chk_ctl("wr_idle", 0, 0, 2'b00, 0, 0);
    // Stray mem_done in IDLE with nobody requesting.
    mem_done = 1;
    step();
    chk_ctl("stray1", 0, 0, 2'b00, 0, 0);
    step();
    chk_ctl("stray2", 0, 0, 2'b00, 0, 0);
    mem_done = 0;

    // Both requests held across two transfers, starting from a fresh reset.
    RST = 1; step(); RST = 0;
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h300; if_addr = 32'h100;
    step();
    chk_ctl("tie1_serve", 1, 0, 2'b10, 0, 0);
    chk("tie1_maddr", 256'(mem_addr), 256'h300);
    mem_done = 1; mem_rdata = PAT_77;
    step();
    mem_done = 0;
    chk_ctl("tie1_rel", 0, 0, 2'b10, 0, 1);
    chk("tie1_dmrdata", dm_rdata, PAT_77);
    step();
    chk_ctl("tie_idle", 0, 0, 2'b00, 0, 0);
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chk_ctl("tie2_serve", 1, 0, 2'b01, 0, 0);
    chk("tie2_maddr", 256'(mem_addr), 256'h100);
`else
    chk_ctl("tie2_serve", 1, 0, 2'b10, 0, 0);
    chk("tie2_maddr", 256'(mem_addr), 256'h300);
`endif
    mem_done = 1; mem_rdata = PAT_66;
    step();
    mem_done = 0;
`ifdef ARB_ROUND_ROBIN_EN
    chk_ctl("tie2_rel", 0, 0, 2'b01, 1, 0);
    chk("tie2_ifrdata", if_rdata, PAT_66);
    chk("tie2_dmrdata", dm_rdata, PAT_77);
`else
    chk_ctl("tie2_rel", 0, 0, 2'b10, 0, 1);
    chk("tie2_dmrdata", dm_rdata, PAT_66);
    chk("tie2_ifrdata", if_rdata, '0);
`endif
    step();
    if_req = 0; dm_req = 0;
    chk_ctl("tie_end", 0, 0, 2'b00, 0, 0);

    // Reset in the 3rd SERVE cycle aborts; held request is re-granted.
    if_req = 1; if_addr = 32'h440;
    step();
    chk_ctl("abort_s1", 1, 0, 2'b01, 0, 0);
    step();
    step();
    chk_ctl("abort_s3", 1, 0, 2'b01, 0, 0);
    RST = 1;
    step();
    RST = 0;
    chk_ctl("abort_after", 0, 0, 2'b00, 0, 0);
    step();
    chk_ctl("abort_regrant", 1, 0, 2'b01, 0, 0);
    chk("abort_maddr", 256'(mem_addr), 256'h440);
    mem_done = 1; mem_rdata = PAT_A5;
    step();
    mem_done = 0;
    chk_ctl("abort_rel", 0, 0, 2'b01, 1, 0);
    step();
    if_req = 0;
    chk_ctl("abort_idle", 0, 0, 2'b00, 0, 0);
    chk("abort_ifrdata", if_rdata, PAT_A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_arbiter.md
UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

Interface
REQ-001 SHALL have port: CLK  input  1  clock; all state changes on rising edge.
REQ-002 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: if_req  input  1  instruction-fetch read request (level); if_addr  input  32  fetch address.
REQ-004 SHALL have ports: if_rdata  output  256  fetched line; if_ack  output  1  one-cycle completion pulse.
REQ-005 SHALL have ports: dm_req  input  1  data request (level); dm_we  input  1  1=write, 0=read; dm_addr  input  32; dm_wdata  input  256.
REQ-006 SHALL have ports: dm_rdata  output  256  read line; dm_ack  output  1  one-cycle completion pulse.
REQ-007 SHALL have ports: mem_read_op, mem_write_op  output  1 each; mem_addr  output  32; mem_wdata  output  256. These drive the UART memory controller.
REQ-008 SHALL have ports: mem_rdata  input  256; mem_busy  input  1  status only; mem_done  input  1  transfer finished.
REQ-009 SHALL have port: grant  output  2  00 none, 01 fetch, 10 data.

Function
REQ-010 SHALL implement FSM IDLE -> SERVE -> RELEASE -> IDLE.
REQ-011 IDLE: if any req is high, SHALL select a winner, latch its addr/we/wdata into internal registers, set grant, and enter SERVE at the next edge; fetch is latched with we=0.
REQ-012 Default arbitration SHALL be fixed priority: dm over if.
REQ-013 SERVE: SHALL drive mem_read_op=~we_l and mem_write_op=we_l continuously; both SHALL never be high together; mem_addr/mem_wdata SHALL come from latched registers only.
REQ-014 SERVE SHALL hold until mem_done=1 is sampled; on that edge SHALL deassert both ops, capture mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged), assert that winner's ack, and enter RELEASE.
REQ-015 RELEASE SHALL last exactly one cycle with ack high, ops low, and grant held; at its end ack=0 and grant=00.
REQ-016 Requesters SHALL drop req on the edge at which they sample ack=1; the arbiter SHALL NOT mask requests.
REQ-017 Changes to req/addr/we/wdata after latching SHALL be ignored until the next IDLE; a req dropped during SERVE SHALL NOT abort the transfer.
REQ-018 mem_done and mem_rdata outside SERVE SHALL be ignored; mem_busy SHALL NOT affect the FSM.
REQ-019 Latency: req high in IDLE cycle 0 -> op high cycles 1..N (mem_done high in cycle N) -> ack in cycle N+1 -> IDLE in cycle N+2; minimum 3 cycles per transfer.
REQ-020 if_rdata/dm_rdata SHALL hold their last captured value until overwritten.

Reset
REQ-021 On RST: state=IDLE; ops, acks=0; grant=00; mem_addr, mem_wdata, if_rdata, dm_rdata=0; last-served=fetch.
REQ-022 RST in SERVE SHALL drop ops on that edge with no ack; the aborted request SHALL be re-arbitrated if still asserted.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN: when defined, on simultaneous requests the port not served last SHALL win; last-served updates on each grant; after reset dm wins the first tie.
REQ-024 When ARB_ROUND_ROBIN_EN is undefined, REQ-012 fixed priority SHALL apply and the last-served register SHALL be absent.

Verification
REQ-025 Fetch read: if_req=1, if_addr=0x100, mem_done after 5 SERVE cycles with mem_rdata=0xA5..A5 -> mem_read_op high 5 cycles, if_rdata=0xA5..A5, if_ack one pulse, grant=01 then 00.
REQ-026 Data write: dm_we=1, dm_addr=0x200, dm_wdata=0x1234 -> mem_write_op only, mem_addr=0x200, mem_wdata=0x1234; dm_ack pulse; dm_rdata unchanged.
REQ-027 Simultaneous if_req and dm_req held over two transfers -> fixed mode: dm, dm; ARB_ROUND_ROBIN_EN: dm then if.
REQ-028 dm_addr changed to 0x999 mid-SERVE -> mem_addr stays at the latched value; stray mem_done=1 in IDLE -> no ack.
REQ-029 RST asserted in the 3rd SERVE cycle -> next cycle ops=0, acks=0, grant=00; req still high -> new grant follows.
